// File: rtl/mux_arbiter2_pkg.sv
// mux_arbiter2_pkg: shared state encoding and source-select constants for mux_arbiter2
package mux_arbiter2_pkg;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT_A = 2'd1;
   localparam logic [1:0] ST_GRANT_B = 2'd2;
   localparam logic SRC_A = 1'b1;
   localparam logic SRC_B = 1'b0;
   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      GRANT_A = ST_GRANT_A,
      GRANT_B = ST_GRANT_B
   } state_t;
endpackage

// File: rtl/mux_arbiter2_out_slot.sv
// mux_arbiter2_out_slot: single-entry valid/ready output register
//  clock, reset_n          clock and synchronous active-low reset
//  fill, fill_data         load a word at the next edge
//  out_valid, out_data     held word, valid until consumed
//  out_ready               downstream consumes when out_valid && out_ready
//  slot_free               a fill this cycle will not overwrite an unconsumed word
module mux_arbiter2_out_slot
   import mux_arbiter2_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             fill,
   input  logic [WIDTH-1:0] fill_data,
   input  logic             out_ready,
   output logic             slot_free,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   always_comb begin
      slot_free = !valid_q || out_ready;
      valid_d   = fill || (valid_q && !out_ready);
      data_d    = fill ? fill_data : data_q;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign out_valid = valid_q;
   assign out_data  = data_q;
endmodule

// File: rtl/mux_arbiter2.sv
// mux_arbiter2: burst-limited round-robin arbiter feeding a single-entry output slot
//  clock, reset_n                clock and synchronous active-low reset
//  req_a/data_a/ack_a            source A handshake (ack combinational)
//  req_b/data_b/ack_b            source B handshake (ack combinational)
//  control                       registered select, 1 = A granted
//  out_data/out_valid/out_ready  registered output word with valid/ready handshake
module mux_arbiter2
   import mux_arbiter2_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             ack_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             ack_b,
   output logic             control,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int CW = $clog2(MAX_BURST + 1);
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            last_q, last_d;
   logic            control_q, control_d;
   logic            burst_done, slot_free, fill;
   logic [WIDTH-1:0] fill_data;
   always_comb begin
      // reset_n gate keeps a held grant from acking during the reset cycle
      ack_a      = reset_n && state_q == GRANT_A && req_a && slot_free;
      ack_b      = reset_n && state_q == GRANT_B && req_b && slot_free;
      fill       = ack_a || ack_b;
      fill_data  = ack_a ? data_a : data_b;
      cnt_inc    = cnt_q + CW'(1);
      burst_done = cnt_inc == CW'(MAX_BURST);
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      case (state_q)
         IDLE: state_d = (req_a && req_b) ? (last_q == SRC_A ? GRANT_B : GRANT_A) :
                         req_a ? GRANT_A : req_b ? GRANT_B : IDLE;
         GRANT_A: begin
            if (!req_a) begin
               state_d = req_b ? GRANT_B : IDLE;
               cnt_d   = '0;
            end else if (ack_a) begin
               last_d  = SRC_A;
               cnt_d   = burst_done ? '0 : cnt_inc;
               state_d = (burst_done && req_b) ? GRANT_B : GRANT_A;
            end
         end
         GRANT_B: begin
            if (!req_b) begin
               state_d = req_a ? GRANT_A : IDLE;
               cnt_d   = '0;
            end else if (ack_b) begin
               last_d  = SRC_B;
               cnt_d   = burst_done ? '0 : cnt_inc;
               state_d = (burst_done && req_a) ? GRANT_A : GRANT_B;
            end
         end
         default: state_d = IDLE;
      endcase
      control_d = state_d == GRANT_A;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= SRC_B;
         control_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         control_q <= control_d;
      end
   end
   assign control = control_q;
   mux_arbiter2_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clock     (clock),
      .reset_n   (reset_n),
      .fill      (fill),
      .fill_data (fill_data),
      .out_ready (out_ready),
      .slot_free (slot_free),
      .out_valid (out_valid),
      .out_data  (out_data)
   );
endmodule

// File: tb/tb_mux_arbiter2.sv
// tb_mux_arbiter2: random and directed checks of mux_arbiter2 against a behavioural model
module tb_mux_arbiter2;
   logic       clock = 1'b0;
   logic       reset_n, req_a, req_b, out_ready;
   logic [7:0] data_a, data_b;
   logic [1:0] aa, ab, ctl, ov;
   logic [7:0] od0, od1;
   int         total = 0;
   int         bad = 0;
   bit         armed = 1'b0;
   always #5 clock = ~clock;
   mux_arbiter2 #(.WIDTH(8), .MAX_BURST(4)) dut (
      .clock(clock), .reset_n(reset_n), .req_a(req_a), .data_a(data_a), .ack_a(aa[0]),
      .req_b(req_b), .data_b(data_b), .ack_b(ab[0]), .control(ctl[0]),
      .out_data(od0), .out_valid(ov[0]), .out_ready(out_ready)
   );
   mux_arbiter2 #(.WIDTH(8), .MAX_BURST(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .req_a(req_a), .data_a(data_a), .ack_a(aa[1]),
      .req_b(req_b), .data_b(data_b), .ack_b(ab[1]), .control(ctl[1]),
      .out_data(od1), .out_valid(ov[1]), .out_ready(out_ready)
   );
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask
   // model: owner 0 = nobody, 1 = A, 2 = B; run = words in current burst
   int         owner[2] = '{0, 0};
   int         run[2] = '{0, 0};
   int         mb[2] = '{4, 1};
   bit         last_was_a[2] = '{0, 0};
   bit         vld[2] = '{0, 0};
   logic [7:0] dat[2] = '{8'h00, 8'h00};
   always @(negedge clock) begin
      for (int m = 0; m < 2; m++) begin
         bit ea, eb, free;
         free = !vld[m] || out_ready;
         ea = reset_n && owner[m] == 1 && req_a && free;
         eb = reset_n && owner[m] == 2 && req_b && free;
         if (armed) begin
            check($sformatf("ack_a[%0d]", m), aa[m], ea);
            check($sformatf("ack_b[%0d]", m), ab[m], eb);
            check($sformatf("control[%0d]", m), ctl[m], owner[m] == 1);
            check($sformatf("out_valid[%0d]", m), ov[m], vld[m]);
            check($sformatf("out_data[%0d]", m), m == 0 ? od0 : od1, dat[m]);
         end
         if (!reset_n) begin
            owner[m] = 0; run[m] = 0; last_was_a[m] = 0; vld[m] = 0; dat[m] = 8'h00;
         end else begin
            if (ea || eb) begin
               vld[m] = 1;
               dat[m] = ea ? data_a : data_b;
            end else if (out_ready) vld[m] = 0;
            if (owner[m] == 0) begin
               owner[m] = (req_a && req_b) ? (last_was_a[m] ? 2 : 1) : req_a ? 1 : req_b ? 2 : 0;
            end else begin
               bit mine, other, acked;
               mine  = owner[m] == 1 ? req_a : req_b;
               other = owner[m] == 1 ? req_b : req_a;
               acked = ea || eb;
               if (!mine) begin
                  owner[m] = other ? 3 - owner[m] : 0;
                  run[m] = 0;
               end else if (acked) begin
                  last_was_a[m] = owner[m] == 1;
                  run[m]++;
                  if (run[m] == mb[m]) begin
                     run[m] = 0;
                     if (other) owner[m] = 3 - owner[m];
                  end
               end
            end
         end
      end
   end
   task automatic step();
      @(posedge clock);
      #1;
      data_a = 8'($urandom);
      data_b = 8'($urandom);
   endtask
   initial begin
      int na, nb, n1a, tog;
      logic prev;
      logic [7:0] hold;
      reset_n = 0; req_a = 0; req_b = 0; out_ready = 1; data_a = 0; data_b = 0;
      repeat (2) step();
      armed = 1;
      reset_n = 1;
      @(negedge clock);
      check("rst_control", ctl[0], 0);
      check("rst_out_valid", ov[0], 0);
      check("rst_out_data", od0, 0);
      check("rst_ack_a", aa[0], 0);
      check("rst_ack_b", ab[0], 0);
      step();
      req_a = 1; data_a = 8'h5A;
      step();
      data_a = 8'h5A;
      @(negedge clock);
      check("t2_control", ctl[0], 1);
      check("t2_ack_a", aa[0], 1);
      step();
      req_a = 0;
      @(negedge clock);
      check("t2_out_data", od0, 8'h5A);
      check("t2_out_valid", ov[0], 1);
      step();
      reset_n = 0;
      step();
      reset_n = 1; req_a = 1; req_b = 1;
      step();
      na = 0; nb = 0; n1a = 0; tog = 0; prev = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         na += int'(aa[0]);
         nb += int'(ab[0]);
         n1a += int'(aa[1]);
         if (i > 0 && aa[1] != prev) tog++;
         prev = aa[1];
         step();
      end
      check("t3_a_words", na, 8);
      check("t3_b_words", nb, 8);
      check("t6_a_words", n1a, 8);
      check("t6_alternation", tog, 15);
      req_b = 0; out_ready = 0;
      repeat (6) step();
      @(negedge clock);
      hold = od0;
      check("t4_blocked_ack", aa[0], 0);
      step();
      @(negedge clock);
      check("t4_data_stable", od0, hold);
      check("t4_valid_held", ov[0], 1);
      step();
      out_ready = 1;
      repeat (3) step();
      req_a = 0; req_b = 1;
      repeat (4) step();
      reset_n = 0;
      @(negedge clock);
      check("t5_no_ack_in_reset", ab[0], 0);
      step();
      reset_n = 1; req_a = 1; req_b = 1;
      @(negedge clock);
      check("t5_valid_cleared", ov[0], 0);
      check("t5_control_cleared", ctl[0], 0);
      step();
      @(negedge clock);
      check("t5_first_grant_a", ctl[0], 1);
      for (int i = 0; i < 3000; i++) begin
         step();
         reset_n   = $urandom_range(0, 99) != 0;
         req_a     = $urandom_range(0, 3) != 0;
         req_b     = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
      end
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
